de_pipe_reg: RTL and testbench

//   D->E pipeline register of the 5-stage MIPS core; feeds E_MDU its operands and md_sel.

---
 rtl/de_pipe_reg_pkg.sv | 29 ++
 rtl/de_pipe_reg_sat_cnt.sv | 30 +++
 rtl/de_pipe_reg.sv | 148 ++++++++++++++
 tb/tb_de_pipe_reg.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/de_pipe_reg_pkg.sv
// Shared encodings for the D->E pipeline register: MDU op selects, exception codes and
// the exception vector used when CP0 flushes the pipe.
package de_pipe_reg_pkg;

   typedef enum logic [3:0] {
      MdNop   = 4'd0,
      MdMult  = 4'd1,
      MdMultu = 4'd2,
      MdDiv   = 4'd3,
      MdDivu  = 4'd4,
      MdMfhi  = 4'd5,
      MdMflo  = 4'd6,
      MdMthi  = 4'd7,
      MdMtlo  = 4'd8
   } md_sel_e;

   typedef enum logic [4:0] {
      ExcNone    = 5'd0,
      ExcAdEL    = 5'd4,
      ExcAdES    = 5'd5,
      ExcSyscall = 5'd8,
      ExcRI      = 5'd10,
      ExcOv      = 5'd12
   } exc_code_e;

   localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
   localparam int unsigned CNT_W_DEF     = 32;

endpackage

// File: rtl/de_pipe_reg_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by reset.
module de_pipe_reg_sat_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/de_pipe_reg.sv
// D->E pipeline register: decides advance / bubble / flush each cycle, feeds the MDU its
// operands and op select, and counts stall cycles.
module de_pipe_reg
   import de_pipe_reg_pkg::*;
#(
   parameter int unsigned       WIDTH     = 32,
   parameter int unsigned       MD_SEL_W  = 4,
   parameter int unsigned       EXC_W     = 5,
   parameter logic [WIDTH-1:0]  EXC_ENTRY = WIDTH'(EXC_ENTRY_DEF),
   parameter int unsigned       CNT_W     = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                d_valid,
   input  logic                d_stall_data,
   input  logic                d_md_class,
   input  logic                md_busy,
   input  logic [WIDTH-1:0]    d_pc,
   input  logic [WIDTH-1:0]    d_instr,
   input  logic [WIDTH-1:0]    d_rs_val,
   input  logic [WIDTH-1:0]    d_rt_val,
   input  logic [WIDTH-1:0]    d_imm,
   input  logic [MD_SEL_W-1:0] d_md_sel,
   input  logic [EXC_W-1:0]    d_exc_code,
   input  logic                d_bd,
   output logic                d_stall,
   output logic [WIDTH-1:0]    e_pc,
   output logic [WIDTH-1:0]    e_instr,
   output logic [WIDTH-1:0]    e_rs_val,
   output logic [WIDTH-1:0]    e_rt_val,
   output logic [WIDTH-1:0]    e_imm,
   output logic [MD_SEL_W-1:0] e_md_sel,
   output logic [EXC_W-1:0]    e_exc_code,
   output logic                e_bd,
   output logic                e_valid,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    md_stall_cnt
);

   logic stall, md_stall;
   logic stall_inc, md_stall_inc;

   logic [WIDTH-1:0]    pc_q, pc_d;
   logic [WIDTH-1:0]    instr_q, instr_d;
   logic [WIDTH-1:0]    rs_val_q, rs_val_d;
   logic [WIDTH-1:0]    rt_val_q, rt_val_d;
   logic [WIDTH-1:0]    imm_q, imm_d;
   logic [MD_SEL_W-1:0] md_sel_q, md_sel_d;
   logic [EXC_W-1:0]    exc_code_q, exc_code_d;
   logic                bd_q, bd_d;
   logic                valid_q, valid_d;

   assign md_stall     = d_valid & d_md_class & md_busy;
   assign stall        = d_valid & (d_stall_data | (d_md_class & md_busy));
   assign stall_inc    = stall & ~req;
   assign md_stall_inc = md_stall & ~req;

   // Gated by reset so the front end never sees a freeze while the core is held in reset.
   assign d_stall = stall_inc & reset;

   always_comb begin
      pc_d       = d_pc;
      bd_d       = d_bd;
      instr_d    = d_instr;
      rs_val_d   = d_rs_val;
      rt_val_d   = d_rt_val;
      imm_d      = d_imm;
      exc_code_d = d_exc_code;
      valid_d    = 1'b1;
      // A faulting instruction must never start the MDU or touch hi/lo.
      md_sel_d   = (d_exc_code != EXC_W'(ExcNone)) ? MD_SEL_W'(MdNop) : d_md_sel;

      if (req) begin
         pc_d       = EXC_ENTRY;
         bd_d       = 1'b0;
         instr_d    = '0;
         rs_val_d   = '0;
         rt_val_d   = '0;
         imm_d      = '0;
         md_sel_d   = '0;
         exc_code_d = '0;
         valid_d    = 1'b0;
      end else if (stall || !d_valid) begin
         // Bubble keeps pc/bd so EPC is right if an interrupt lands on it.
         instr_d    = '0;
         rs_val_d   = '0;
         rt_val_d   = '0;
         imm_d      = '0;
         md_sel_d   = '0;
         exc_code_d = '0;
         valid_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= '0;
         instr_q    <= '0;
         rs_val_q   <= '0;
         rt_val_q   <= '0;
         imm_q      <= '0;
         md_sel_q   <= '0;
         exc_code_q <= '0;
         bd_q       <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         rs_val_q   <= rs_val_d;
         rt_val_q   <= rt_val_d;
         imm_q      <= imm_d;
         md_sel_q   <= md_sel_d;
         exc_code_q <= exc_code_d;
         bd_q       <= bd_d;
         valid_q    <= valid_d;
      end
   end

   assign e_pc       = pc_q;
   assign e_instr    = instr_q;
   assign e_rs_val   = rs_val_q;
   assign e_rt_val   = rt_val_q;
   assign e_imm      = imm_q;
   assign e_md_sel   = md_sel_q;
   assign e_exc_code = exc_code_q;
   assign e_bd       = bd_q;
   assign e_valid    = valid_q;

   de_pipe_reg_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .cnt   (stall_cnt)
   );

   de_pipe_reg_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_md_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (md_stall_inc),
      .cnt   (md_stall_cnt)
   );

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg; a second instance with 3-bit counters exercises saturation.
module tb_de_pipe_reg;
   import de_pipe_reg_pkg::*;

   logic        clk;
   logic        reset;
   logic        req;
   logic        d_valid;
   logic        d_stall_data;
   logic        d_md_class;
   logic        md_busy;
   logic [31:0] d_pc, d_instr, d_rs_val, d_rt_val, d_imm;
   logic [3:0]  d_md_sel;
   logic [4:0]  d_exc_code;
   logic        d_bd;

   logic        d_stall;
   logic [31:0] e_pc, e_instr, e_rs_val, e_rt_val, e_imm;
   logic [3:0]  e_md_sel;
   logic [4:0]  e_exc_code;
   logic        e_bd, e_valid;
   logic [31:0] stall_cnt, md_stall_cnt;

   logic        s_d_stall;
   logic [31:0] s_pc, s_instr, s_rs_val, s_rt_val, s_imm;
   logic [3:0]  s_md_sel;
   logic [4:0]  s_exc_code;
   logic        s_bd, s_valid;
   logic [2:0]  s_stall_cnt, s_md_stall_cnt;

   int checks = 0;
   int errors = 0;

   de_pipe_reg dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .d_valid      (d_valid),
      .d_stall_data (d_stall_data),
      .d_md_class   (d_md_class),
      .md_busy      (md_busy),
      .d_pc         (d_pc),
      .d_instr      (d_instr),
      .d_rs_val     (d_rs_val),
      .d_rt_val     (d_rt_val),
      .d_imm        (d_imm),
      .d_md_sel     (d_md_sel),
      .d_exc_code   (d_exc_code),
      .d_bd         (d_bd),
      .d_stall      (d_stall),
      .e_pc         (e_pc),
      .e_instr      (e_instr),
      .e_rs_val     (e_rs_val),
      .e_rt_val     (e_rt_val),
      .e_imm        (e_imm),
      .e_md_sel     (e_md_sel),
      .e_exc_code   (e_exc_code),
      .e_bd         (e_bd),
      .e_valid      (e_valid),
      .stall_cnt    (stall_cnt),
      .md_stall_cnt (md_stall_cnt)
   );

   de_pipe_reg #(
      .CNT_W (3)
   ) dut_s (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .d_valid      (d_valid),
      .d_stall_data (d_stall_data),
      .d_md_class   (d_md_class),
      .md_busy      (md_busy),
      .d_pc         (d_pc),
      .d_instr      (d_instr),
      .d_rs_val     (d_rs_val),
      .d_rt_val     (d_rt_val),
      .d_imm        (d_imm),
      .d_md_sel     (d_md_sel),
      .d_exc_code   (d_exc_code),
      .d_bd         (d_bd),
      .d_stall      (s_d_stall),
      .e_pc         (s_pc),
      .e_instr      (s_instr),
      .e_rs_val     (s_rs_val),
      .e_rt_val     (s_rt_val),
      .e_imm        (s_imm),
      .e_md_sel     (s_md_sel),
      .e_exc_code   (s_exc_code),
      .e_bd         (s_bd),
      .e_valid      (s_valid),
      .stall_cnt    (s_stall_cnt),
      .md_stall_cnt (s_md_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset        = 1'b0;
      req          = 1'b0;
      d_valid      = 1'b1;
      d_stall_data = 1'b1;
      d_md_class   = 1'b0;
      md_busy      = 1'b0;
      d_pc         = 32'h0000_1234;
      d_instr      = '0;
      d_rs_val     = '0;
      d_rt_val     = '0;
      d_imm        = '0;
      d_md_sel     = '0;
      d_exc_code   = '0;
      d_bd         = 1'b0;

      // 1. reset held low for 3 edges
      #1;
      check("rst_d_stall", 32'(d_stall), 32'd0);
      repeat (3) tick();
      check("rst_e_pc", e_pc, 32'd0);
      check("rst_e_valid", 32'(e_valid), 32'd0);
      d_valid      = 1'b0;
      d_stall_data = 1'b0;
      reset        = 1'b1;
      #1;
      check("rst_e_instr", e_instr, 32'd0);
      check("rst_e_md_sel", 32'(e_md_sel), 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_md_stall_cnt", md_stall_cnt, 32'd0);
      check("rst_d_stall_rel", 32'(d_stall), 32'd0);

      // 2. plain mult loads with 1-cycle latency
      d_valid    = 1'b1;
      d_md_class = 1'b1;
      d_pc       = 32'h0000_3000;
      d_instr    = 32'h0085_0018;
      d_rs_val   = 32'd5;
      d_rt_val   = 32'd7;
      d_imm      = 32'h0000_0012;
      d_md_sel   = 4'(MdMult);
      #1;
      check("mult_d_stall", 32'(d_stall), 32'd0);
      tick();
      check("mult_e_pc", e_pc, 32'h0000_3000);
      check("mult_e_md_sel", 32'(e_md_sel), 32'(MdMult));
      check("mult_e_valid", 32'(e_valid), 32'd1);
      check("mult_e_rs", e_rs_val, 32'd5);
      check("mult_e_rt", e_rt_val, 32'd7);
      check("mult_e_imm", e_imm, 32'h12);
      check("mult_e_instr", e_instr, 32'h0085_0018);

      // 3. mflo in delay slot, MDU busy for 5 cycles
      d_pc     = 32'h0000_3008;
      d_instr  = 32'h0000_4012;
      d_md_sel = 4'(MdMflo);
      d_bd     = 1'b1;
      md_busy  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("md_d_stall", 32'(d_stall), 32'd1);
         tick();
         check("md_bub_pc", e_pc, 32'h0000_3008);
         check("md_bub_bd", 32'(e_bd), 32'd1);
         check("md_bub_valid", 32'(e_valid), 32'd0);
         check("md_bub_md_sel", 32'(e_md_sel), 32'd0);
         check("md_bub_instr", e_instr, 32'd0);
      end
      check("md_stall_cnt5", md_stall_cnt, 32'd5);
      check("stall_cnt5", stall_cnt, 32'd5);
      md_busy = 1'b0;
      #1;
      check("mflo_d_stall", 32'(d_stall), 32'd0);
      tick();
      check("mflo_e_valid", 32'(e_valid), 32'd1);
      check("mflo_e_instr", e_instr, 32'h0000_4012);
      check("mflo_e_md_sel", 32'(e_md_sel), 32'(MdMflo));
      check("mflo_cnt_hold", md_stall_cnt, 32'd5);

      // 4. req with data stall: flush wins
      req          = 1'b1;
      d_stall_data = 1'b1;
      d_md_class   = 1'b0;
      d_pc         = 32'h0000_300c;
      d_md_sel     = 4'(MdNop);
      #1;
      check("flush_d_stall", 32'(d_stall), 32'd0);
      tick();
      check("flush_e_pc", e_pc, 32'h0000_4180);
      check("flush_e_valid", 32'(e_valid), 32'd0);
      check("flush_e_bd", 32'(e_bd), 32'd0);
      check("flush_e_instr", e_instr, 32'd0);
      check("flush_stall_cnt", stall_cnt, 32'd5);
      req          = 1'b0;
      d_stall_data = 1'b0;

      // 5. div with RI exception: MDU select suppressed
      d_bd       = 1'b0;
      d_md_class = 1'b1;
      d_pc       = 32'h0000_4180;
      d_instr    = 32'h0085_001a;
      d_md_sel   = 4'(MdDiv);
      d_exc_code = 5'(ExcRI);
      tick();
      check("exc_e_md_sel", 32'(e_md_sel), 32'd0);
      check("exc_e_exc", 32'(e_exc_code), 32'd10);
      check("exc_e_valid", 32'(e_valid), 32'd1);
      check("exc_e_pc", e_pc, 32'h0000_4180);
      d_exc_code = '0;

      // d_valid=0 loads as bubble with pc/bd kept; busy MDU does not stall it
      d_valid = 1'b0;
      d_pc    = 32'h0000_5000;
      d_bd    = 1'b1;
      md_busy = 1'b1;
      #1;
      check("inv_d_stall", 32'(d_stall), 32'd0);
      tick();
      check("inv_e_valid", 32'(e_valid), 32'd0);
      check("inv_e_pc", e_pc, 32'h0000_5000);
      check("inv_e_bd", 32'(e_bd), 32'd1);
      check("inv_e_instr", e_instr, 32'd0);
      check("inv_md_cnt", md_stall_cnt, 32'd5);
      md_busy = 1'b0;

      // 6. data stall for 4 cycles; 3-bit counter saturates at 7
      d_valid      = 1'b1;
      d_stall_data = 1'b1;
      d_md_class   = 1'b0;
      d_pc         = 32'h0000_6000;
      tick();
      check("sat_big6", stall_cnt, 32'd6);
      check("sat_small6", 32'(s_stall_cnt), 32'd6);
      tick();
      check("sat_small7", 32'(s_stall_cnt), 32'd7);
      tick();
      check("sat_small_hold1", 32'(s_stall_cnt), 32'd7);
      tick();
      check("sat_small_hold2", 32'(s_stall_cnt), 32'd7);
      check("sat_big9", stall_cnt, 32'd9);
      check("sat_small_md", 32'(s_md_stall_cnt), 32'd5);
      check("stall_bub_pc", e_pc, 32'h0000_6000);

      // reset asserted mid-stall clears everything without waiting for an edge
      reset = 1'b0;
      #1;
      check("mid_rst_e_pc", e_pc, 32'd0);
      check("mid_rst_e_bd", 32'(e_bd), 32'd0);
      check("mid_rst_stall_cnt", stall_cnt, 32'd0);
      check("mid_rst_md_cnt", md_stall_cnt, 32'd0);
      check("mid_rst_small_cnt", 32'(s_stall_cnt), 32'd0);
      check("mid_rst_d_stall", 32'(d_stall), 32'd0);
      reset = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
